// File: rtl/dispatch_router_if.sv
// Bundle of the rename-side, wakeup-side and issue-queue-side signals of the
// dispatch buffer. "master" is the environment (renamer, FUs, issue queues),
// "slave" is the dispatch_router itself.
interface dispatch_router_if #(
    parameter int FU_COUNT     = 4,
    parameter int MAX_OPERANDS = 3,
    parameter int PRN_BITS     = 6,
    parameter int INST_ID_BITS = 6,
    parameter int DEPTH        = 4
);
    localparam int FW = $clog2(FU_COUNT);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = MAX_OPERANDS * PRN_BITS;
    localparam int NW = FU_COUNT * MAX_OPERANDS;

    // renamer -> buffer
    logic                    in_valid;
    logic [INST_ID_BITS-1:0] in_inst_id;
    logic [31:0]             in_raw_instr;
    logic [63:0]             in_instr_pc;
    logic [FW-1:0]           in_fu_choice;
    logic [MAX_OPERANDS-1:0] in_src_valid;
    logic [MAX_OPERANDS-1:0] in_src_ready;
    logic [SW-1:0]           in_src_prn;
    logic [MAX_OPERANDS-1:0] in_dst_valid;
    logic [SW-1:0]           in_dst_prn;
    // FU result broadcasts and ROB flush
    logic [NW-1:0]           wake_valid;
    logic [NW*PRN_BITS-1:0]  wake_prn;
    logic                    flush;
    // issue queues
    logic [FU_COUNT-1:0]     fu_ready;
    logic [FU_COUNT-1:0]     out_valid;
    logic [INST_ID_BITS-1:0] out_inst_id;
    logic [31:0]             out_raw_instr;
    logic [63:0]             out_instr_pc;
    logic [MAX_OPERANDS-1:0] out_src_valid;
    logic [MAX_OPERANDS-1:0] out_src_ready;
    logic [SW-1:0]           out_src_prn;
    logic [MAX_OPERANDS-1:0] out_dst_valid;
    logic [SW-1:0]           out_dst_prn;
    // back-pressure and occupancy
    logic                    stall_rename;
    logic [CW-1:0]           count;

    modport master (
        output in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice,
               in_src_valid, in_src_ready, in_src_prn, in_dst_valid, in_dst_prn,
               wake_valid, wake_prn, flush, fu_ready,
        input  out_valid, out_inst_id, out_raw_instr, out_instr_pc,
               out_src_valid, out_src_ready, out_src_prn, out_dst_valid, out_dst_prn,
               stall_rename, count
    );

    modport slave (
        input  in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice,
               in_src_valid, in_src_ready, in_src_prn, in_dst_valid, in_dst_prn,
               wake_valid, wake_prn, flush, fu_ready,
        output out_valid, out_inst_id, out_raw_instr, out_instr_pc,
               out_src_valid, out_src_ready, out_src_prn, out_dst_valid, out_dst_prn,
               stall_rename, count
    );
endinterface

// File: rtl/dispatch_router.sv
// In-order dispatch buffer between the renamer and the FU issue queues.
// A DEPTH-entry circular FIFO; the head entry is offered to the queue picked
// by its fu_choice, and source ready bits are kept current from FU wakeups.
// Full/empty is tracked by the occupancy counter, never by pointer compare.
module dispatch_router #(
    parameter int FU_COUNT     = 4,
    parameter int MAX_OPERANDS = 3,
    parameter int PRN_BITS     = 6,
    parameter int INST_ID_BITS = 6,
    parameter int DEPTH        = 4
) (
    input  logic               clk,
    input  logic               rst,
    dispatch_router_if.slave   bus
);
    localparam int FW = $clog2(FU_COUNT);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = MAX_OPERANDS * PRN_BITS;
    localparam int NW = FU_COUNT * MAX_OPERANDS;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // True when any valid broadcast carries the given physical register.
    function automatic logic wake_hit(
        input logic [PRN_BITS-1:0]    prn,
        input logic [NW-1:0]          wv,
        input logic [NW*PRN_BITS-1:0] wp
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NW; k++) begin
            hit = hit | (wv[k] & (wp[k*PRN_BITS +: PRN_BITS] == prn));
        end
        return hit;
    endfunction

    // Pointers, occupancy and per-entry valid bits (reset state)
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DEPTH-1:0]        vld_q, vld_d;

    // Entry payload (meaningful only while the entry is valid)
    logic [INST_ID_BITS-1:0] id_q    [DEPTH];
    logic [INST_ID_BITS-1:0] id_d    [DEPTH];
    logic [31:0]             instr_q [DEPTH];
    logic [31:0]             instr_d [DEPTH];
    logic [63:0]             pc_q    [DEPTH];
    logic [63:0]             pc_d    [DEPTH];
    logic [FW-1:0]           fu_q    [DEPTH];
    logic [FW-1:0]           fu_d    [DEPTH];
    logic [MAX_OPERANDS-1:0] srcv_q  [DEPTH];
    logic [MAX_OPERANDS-1:0] srcv_d  [DEPTH];
    logic [MAX_OPERANDS-1:0] srcr_q  [DEPTH];
    logic [MAX_OPERANDS-1:0] srcr_d  [DEPTH];
    logic [SW-1:0]           srcp_q  [DEPTH];
    logic [SW-1:0]           srcp_d  [DEPTH];
    logic [MAX_OPERANDS-1:0] dstv_q  [DEPTH];
    logic [MAX_OPERANDS-1:0] dstv_d  [DEPTH];
    logic [SW-1:0]           dstp_q  [DEPTH];
    logic [SW-1:0]           dstp_d  [DEPTH];

    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;
    logic [FU_COUNT-1:0]     out_valid_s;
    logic [MAX_OPERANDS-1:0] in_rdy_s;
    logic [MAX_OPERANDS-1:0] head_rdy_s;

    // Handshake decode: stall from registered count only, head offer gated by flush
    always_comb begin
        full_s      = (count_q == FULL_CNT);
        push_s      = bus.in_valid & ~full_s & ~bus.flush;
        out_valid_s = '0;
        if ((count_q != '0) && !bus.flush) begin
            out_valid_s[fu_q[head_q]] = 1'b1;
        end else begin
            out_valid_s = '0;
        end
        pop_s = |(out_valid_s & bus.fu_ready);
    end

    // Same-cycle wake forwarding for the incoming instruction and the head entry
    always_comb begin
        in_rdy_s   = '0;
        head_rdy_s = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            in_rdy_s[i] = bus.in_src_ready[i]
                        | (bus.in_src_valid[i]
                           & wake_hit(bus.in_src_prn[i*PRN_BITS +: PRN_BITS],
                                      bus.wake_valid, bus.wake_prn));
            head_rdy_s[i] = srcr_q[head_q][i]
                          | (srcv_q[head_q][i]
                             & wake_hit(srcp_q[head_q][i*PRN_BITS +: PRN_BITS],
                                        bus.wake_valid, bus.wake_prn));
        end
    end

    // Next-state: flush wins; otherwise wakeup, pop at head, push at tail
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        for (int e = 0; e < DEPTH; e++) begin
            id_d[e]    = id_q[e];
            instr_d[e] = instr_q[e];
            pc_d[e]    = pc_q[e];
            fu_d[e]    = fu_q[e];
            srcv_d[e]  = srcv_q[e];
            srcr_d[e]  = srcr_q[e];
            srcp_d[e]  = srcp_q[e];
            dstv_d[e]  = dstv_q[e];
            dstp_d[e]  = dstp_q[e];
        end

        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            vld_d   = '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int i = 0; i < MAX_OPERANDS; i++) begin
                    if (vld_q[e] && srcv_q[e][i] &&
                        wake_hit(srcp_q[e][i*PRN_BITS +: PRN_BITS],
                                 bus.wake_valid, bus.wake_prn)) begin
                        srcr_d[e][i] = 1'b1;
                    end else begin
                        srcr_d[e][i] = srcr_q[e][i];
                    end
                end
            end

            if (pop_s) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end

            // Push never targets the head slot: a push needs the buffer not full
            if (push_s) begin
                vld_d[tail_q]   = 1'b1;
                id_d[tail_q]    = bus.in_inst_id;
                instr_d[tail_q] = bus.in_raw_instr;
                pc_d[tail_q]    = bus.in_instr_pc;
                fu_d[tail_q]    = bus.in_fu_choice;
                srcv_d[tail_q]  = bus.in_src_valid;
                srcr_d[tail_q]  = in_rdy_s;
                srcp_d[tail_q]  = bus.in_src_prn;
                dstv_d[tail_q]  = bus.in_dst_valid;
                dstp_d[tail_q]  = bus.in_dst_prn;
                tail_d          = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end

            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Payload storage; qualified by vld_q so it needs no reset
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            id_q[e]    <= id_d[e];
            instr_q[e] <= instr_d[e];
            pc_q[e]    <= pc_d[e];
            fu_q[e]    <= fu_d[e];
            srcv_q[e]  <= srcv_d[e];
            srcr_q[e]  <= srcr_d[e];
            srcp_q[e]  <= srcp_d[e];
            dstv_q[e]  <= dstv_d[e];
            dstp_q[e]  <= dstp_d[e];
        end
    end

    assign bus.out_valid     = out_valid_s;
    assign bus.out_inst_id   = id_q[head_q];
    assign bus.out_raw_instr = instr_q[head_q];
    assign bus.out_instr_pc  = pc_q[head_q];
    assign bus.out_src_valid = srcv_q[head_q];
    assign bus.out_src_ready = head_rdy_s;
    assign bus.out_src_prn   = srcp_q[head_q];
    assign bus.out_dst_valid = dstv_q[head_q];
    assign bus.out_dst_prn   = dstp_q[head_q];
    assign bus.stall_rename  = full_s;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: directed scenarios plus a randomized phase, all
// checked against a queue-based reference model of the dispatch buffer.
module tb_dispatch_router;
    localparam int FU_COUNT     = 4;
    localparam int MAX_OPERANDS = 3;
    localparam int PRN_BITS     = 6;
    localparam int INST_ID_BITS = 6;
    localparam int DEPTH        = 4;
    localparam int NW           = FU_COUNT * MAX_OPERANDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dispatch_router_if #(
        .FU_COUNT(FU_COUNT), .MAX_OPERANDS(MAX_OPERANDS), .PRN_BITS(PRN_BITS),
        .INST_ID_BITS(INST_ID_BITS), .DEPTH(DEPTH)
    ) bus ();

    dispatch_router #(
        .FU_COUNT(FU_COUNT), .MAX_OPERANDS(MAX_OPERANDS), .PRN_BITS(PRN_BITS),
        .INST_ID_BITS(INST_ID_BITS), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [1:0]  fu;
        logic [2:0]  srcv;
        logic [2:0]  srcr;
        logic [17:0] srcp;
        logic [2:0]  dstv;
        logic [17:0] dstp;
    } ent_t;

    ent_t mq[$];        // reference FIFO, oldest at index 0
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_wake(input logic [PRN_BITS-1:0] p);
        for (int k = 0; k < NW; k++) begin
            if (bus.wake_valid[k] && bus.wake_prn[k*PRN_BITS +: PRN_BITS] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_inst_id   = '0;
        bus.in_raw_instr = '0;
        bus.in_instr_pc  = '0;
        bus.in_fu_choice = '0;
        bus.in_src_valid = '0;
        bus.in_src_ready = '0;
        bus.in_src_prn   = '0;
        bus.in_dst_valid = '0;
        bus.in_dst_prn   = '0;
        bus.wake_valid   = '0;
        bus.wake_prn     = '0;
        bus.flush        = 1'b0;
        bus.fu_ready     = '0;
    endtask

    task automatic load_instr(input logic [5:0] id, input logic [1:0] fu,
                              input logic [2:0] sv, input logic [2:0] sr, input logic [17:0] sp);
        bus.in_valid     = 1'b1;
        bus.in_inst_id   = id;
        bus.in_fu_choice = fu;
        bus.in_src_valid = sv;
        bus.in_src_ready = sr;
        bus.in_src_prn   = sp;
        bus.in_raw_instr = $urandom;
        bus.in_instr_pc  = {$urandom, $urandom};
        bus.in_dst_valid = 3'($urandom_range(0, 7));
        bus.in_dst_prn   = 18'($urandom);
    endtask

    // Compare every visible output against the model before the clock edge
    task automatic model_check();
        logic [FU_COUNT-1:0] ev;
        logic [2:0]          er;
        ev = '0;
        if (mq.size() != 0 && !bus.flush) ev[mq[0].fu] = 1'b1;
        check_val("count", bus.count, mq.size());
        check_val("stall_rename", bus.stall_rename, mq.size() == DEPTH);
        check_val("out_valid", bus.out_valid, ev);
        if (ev != '0) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                er[i] = mq[0].srcv[i] & (mq[0].srcr[i] | ref_wake(mq[0].srcp[i*PRN_BITS +: PRN_BITS]));
            end
            check_val("out_inst_id", bus.out_inst_id, mq[0].id);
            check_val("out_raw_instr", bus.out_raw_instr, mq[0].instr);
            check_val("out_instr_pc", bus.out_instr_pc, mq[0].pc);
            check_val("out_src_valid", bus.out_src_valid, mq[0].srcv);
            check_val("out_src_ready", bus.out_src_ready & bus.out_src_valid, er);
            check_val("out_src_prn", bus.out_src_prn, mq[0].srcp);
            check_val("out_dst_valid", bus.out_dst_valid, mq[0].dstv);
            check_val("out_dst_prn", bus.out_dst_prn, mq[0].dstp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_update();
        ent_t e;
        int   sz;
        bit   do_pop, do_push;
        sz = mq.size();
        if (bus.flush) begin
            mq.delete();
            return;
        end
        do_pop  = (sz != 0) && bus.fu_ready[mq[0].fu];
        do_push = bus.in_valid && (sz < DEPTH);
        for (int j = 0; j < sz; j++) begin
            e = mq[j];
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (e.srcv[i] && ref_wake(e.srcp[i*PRN_BITS +: PRN_BITS])) e.srcr[i] = 1'b1;
            end
            mq[j] = e;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.id    = bus.in_inst_id;
            e.instr = bus.in_raw_instr;
            e.pc    = bus.in_instr_pc;
            e.fu    = bus.in_fu_choice;
            e.srcv  = bus.in_src_valid;
            e.srcp  = bus.in_src_prn;
            e.dstv  = bus.in_dst_valid;
            e.dstp  = bus.in_dst_prn;
            e.srcr  = bus.in_src_ready;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (e.srcv[i] && ref_wake(e.srcp[i*PRN_BITS +: PRN_BITS])) e.srcr[i] = 1'b1;
            end
            mq.push_back(e);
        end
    endtask

    task automatic settle();
        #3;
        model_check();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        clock_edge();
    endtask

    // Asynchronous reset pulse between edges; state must clear immediately
    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        mq.delete();
        check_val("rst_count", bus.count, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_stall", bus.stall_rename, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("init_count", bus.count, 0);
        check_val("init_out_valid", bus.out_valid, 0);
        check_val("init_stall", bus.stall_rename, 0);

        // Reset mid-stream with three entries resident
        for (int n = 0; n < 3; n++) begin
            load_instr(6'(n), 2'(n), 3'b000, 3'b000, 18'd0);
            step();
        end
        idle();
        settle();
        check_val("t1_pre_count", bus.count, 3);
        do_reset();
        settle();

        // Fill to DEPTH with all queues stalled; fifth instruction is refused
        for (int n = 0; n < 4; n++) begin
            load_instr(6'(n), 2'(n), 3'($urandom_range(0, 7)), 3'b000, 18'($urandom));
            step();
        end
        load_instr(6'd4, 2'd0, 3'b001, 3'b000, 18'd5);
        settle();
        check_val("t2_count", bus.count, 4);
        check_val("t2_stall", bus.stall_rename, 1);
        check_val("t2_out_valid", bus.out_valid, 4'b0001);
        clock_edge();
        check_val("t2_no_push", bus.count, 4);

        // Full: pop without push, then push and pop together
        bus.fu_ready = 4'b0001;
        settle();
        check_val("t3_head_id", bus.out_inst_id, 0);
        clock_edge();
        check_val("t3_count_after_pop", bus.count, 3);
        bus.fu_ready = 4'b0010;
        settle();
        check_val("t3_stall_reopen", bus.stall_rename, 0);
        clock_edge();
        check_val("t3_count_push_pop", bus.count, 3);
        idle();
        bus.fu_ready = 4'b1111;
        repeat (4) step();
        check_val("t3_drained", bus.count, 0);

        // Wakeup of a waiting head operand, forwarded then held
        idle();
        load_instr(6'd10, 2'd3, 3'b001, 3'b000, {6'd40, 6'd41, 6'd17});
        step();
        idle();
        bus.wake_valid[2] = 1'b1;
        bus.wake_prn[2*PRN_BITS +: PRN_BITS] = 6'd17;
        settle();
        check_val("t4_fwd_ready", bus.out_src_ready[0], 1);
        clock_edge();
        idle();
        settle();
        check_val("t4_held_ready", bus.out_src_ready[0], 1);
        clock_edge();
        do_reset();

        // Head blocked by its queue holds back a younger ready-to-go entry
        load_instr(6'd20, 2'd2, 3'b000, 3'b000, 18'd0);
        step();
        load_instr(6'd21, 2'd0, 3'b000, 3'b000, 18'd0);
        step();
        idle();
        bus.fu_ready = 4'b1011;
        settle();
        check_val("t5_blocked_ov", bus.out_valid, 4'b0100);
        clock_edge();
        check_val("t5_blocked_count", bus.count, 2);
        bus.fu_ready = 4'b0100;
        settle();
        check_val("t5_first_id", bus.out_inst_id, 20);
        clock_edge();
        bus.fu_ready = 4'b1111;
        settle();
        check_val("t5_second_ov", bus.out_valid, 4'b0001);
        check_val("t5_second_id", bus.out_inst_id, 21);
        clock_edge();
        do_reset();

        // Flush beats a simultaneous push; buffer restarts from slot 0
        load_instr(6'd30, 2'd1, 3'b000, 3'b000, 18'd0);
        step();
        load_instr(6'd31, 2'd2, 3'b000, 3'b000, 18'd0);
        step();
        load_instr(6'd32, 2'd0, 3'b000, 3'b000, 18'd0);
        bus.flush    = 1'b1;
        bus.fu_ready = 4'b1111;
        settle();
        check_val("t6_flush_ov", bus.out_valid, 0);
        clock_edge();
        idle();
        settle();
        check_val("t6_count", bus.count, 0);
        check_val("t6_empty_ov", bus.out_valid, 0);
        clock_edge();
        load_instr(6'd33, 2'd1, 3'b000, 3'b000, 18'd0);
        step();
        idle();
        settle();
        check_val("t6_restart_ov", bus.out_valid, 4'b0010);
        check_val("t6_restart_id", bus.out_inst_id, 33);
        clock_edge();
        do_reset();

        // Randomized traffic: small PRN range so wakeups hit often
        for (int c = 0; c < 600; c++) begin
            bus.in_valid     = ($urandom_range(0, 99) < 70);
            bus.in_inst_id   = 6'($urandom);
            bus.in_raw_instr = $urandom;
            bus.in_instr_pc  = {$urandom, $urandom};
            bus.in_fu_choice = 2'($urandom);
            bus.in_src_valid = 3'($urandom);
            bus.in_src_ready = 3'($urandom);
            bus.in_dst_valid = 3'($urandom);
            bus.in_dst_prn   = 18'($urandom);
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                bus.in_src_prn[i*PRN_BITS +: PRN_BITS] = 6'($urandom_range(0, 7));
            end
            for (int k = 0; k < NW; k++) begin
                bus.wake_valid[k] = ($urandom_range(0, 99) < 6);
                bus.wake_prn[k*PRN_BITS +: PRN_BITS] = 6'($urandom_range(0, 7));
            end
            bus.fu_ready = 4'($urandom);
            bus.flush    = ($urandom_range(0, 99) < 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
